// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: requester indices,
// arbitration state encoding and a one-hot helper.
package dmem_arb_pkg;

  localparam int AW_DEF        = 19;
  localparam int DW_DEF        = 19;
  localparam int MAX_BURST_DEF = 4;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Combinational two-way round-robin pick. While locked only the owner can win;
// otherwise a tie goes to the requester that was not served last.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  input  logic       locked_i,
  input  logic       owner_i,
  output logic [1:0] grant_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_o = 2'b00;
    if (locked_i) begin
      if (valid_i[owner_i]) grant_o = idx2onehot(owner_i);
    end else if (valid_i == 2'b11) begin
      grant_o = idx2onehot(~last_i);
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU and the DMA/debug loader
// with round-robin fairness, bounded locked bursts and a registered read response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [1:0]    req_lock,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0] grant;
  logic       accept, g, rd_accept, burst_end;

  arb_rr2 u_rr (
    .valid_i  (req_valid),
    .last_i   (last_q),
    .locked_i (state_q == LOCK),
    .owner_i  (owner_q),
    .grant_o  (grant)
  );

  // The asynchronous reset also silences the handshake while it is held low.
  assign req_ready = grant & {2{reset}};
  assign accept    = |req_ready;
  assign g         = req_ready[DMA];
  assign rd_accept = accept & ~req_we[g];
  assign burst_end = (burst_cnt_q + CW'(1)) == CW'(MAX_BURST);

  assign mem_we  = accept & req_we[g];
  assign mem_adr = req_ready[CPU] ? req_addr0  : (req_ready[DMA] ? req_addr1  : '0);
  assign mem_wd  = req_ready[CPU] ? req_wdata0 : (req_ready[DMA] ? req_wdata1 : '0);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;

    if (accept) last_d = g;
    if (rd_accept) begin
      rsp_valid_d = req_ready;
      rsp_rdata_d = mem_rd;
    end

    if (state_q == ARB) begin
      if (accept && req_lock[g] && (MAX_BURST > 1)) begin
        state_d     = LOCK;
        owner_d     = g;
        burst_cnt_d = CW'(1);
      end
    end else if (accept) begin
      if (!req_lock[g] || burst_end) begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end
    end else begin
      // Owner went idle: the lock is released and nobody is served this cycle.
      state_d     = ARB;
      burst_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB;
      last_q      <= DMA;
      owner_q     <= CPU;
      burst_cnt_q <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of grants and memory.
module tb_dmem_arbiter;

  localparam int AW   = 19;
  localparam int DW   = 19;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid, req_we, req_lock;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd, mem_rd;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // Stand-in dmem: combinational read, write at the clock edge, preloaded while in reset.
  logic [DW-1:0] dmem [0:255];
  assign mem_rd = dmem[mem_adr[7:0]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= DW'(i * 37 + 5);
    end else if (mem_we) begin
      dmem[mem_adr[7:0]] <= mem_wd;
    end
  end

  // Reference model: who holds a lock, how many beats it has had, who was served last.
  int            m_last, m_owner, m_beats;
  logic [DW-1:0] ref_mem [0:255];
  logic [1:0]    exp_rsp_valid;
  logic [DW-1:0] exp_rdata;

  int         n_pass = 0, n_total = 0, we_cnt = 0;
  logic [1:0] last_ready = 2'b00;
  logic [11:0] pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int pick();
    if (m_owner >= 0) return req_valid[m_owner[0]] ? m_owner : -1;
    if (req_valid == 2'b11) return 1 - m_last;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic       gi;
    logic [7:0] a;
    gi = g[0];
    exp_rsp_valid = 2'b00;
    if (g >= 0) begin
      a = gi ? req_addr1[7:0] : req_addr0[7:0];
      if (req_we[gi]) ref_mem[a] = gi ? req_wdata1 : req_wdata0;
      else begin
        exp_rsp_valid[gi] = 1'b1;
        exp_rdata         = ref_mem[a];
      end
      m_last = g;
      if (m_owner < 0) begin
        if (req_lock[gi] && MAXB > 1) begin
          m_owner = g;
          m_beats = 1;
        end
      end else begin
        m_beats++;
        if (!req_lock[gi] || m_beats == MAXB) m_owner = -1;
      end
    end else begin
      m_owner = -1;
    end
  endtask

  // One cycle: inputs already driven at posedge+1; sample at the falling edge.
  task automatic step();
    int         g;
    logic       gi;
    logic [1:0] er;
    g  = pick();
    gi = g[0];
    er = (g < 0) ? 2'b00 : (gi ? 2'b10 : 2'b01);
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(er));
    check("mem_we", 32'(mem_we), 32'((g >= 0) ? req_we[gi] : 1'b0));
    check("mem_adr", 32'(mem_adr), 32'((g < 0) ? '0 : (gi ? req_addr1 : req_addr0)));
    check("mem_wd", 32'(mem_wd), 32'((g < 0) ? '0 : (gi ? req_wdata1 : req_wdata0)));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    last_ready = req_ready;
    we_cnt += int'(mem_we);
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_lock  = 2'b00;
    reset     = 1'b0;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'(2'b00));
    check("rst_mem_we", 32'(mem_we), 32'(1'b0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(2'b00));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    m_last        = 1;
    m_owner       = -1;
    m_beats       = 0;
    exp_rsp_valid = 2'b00;
    exp_rdata     = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 37 + 5);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid  = v;
    req_we     = we;
    req_lock   = lk;
    req_addr0  = AW'(a0);
    req_addr1  = AW'(a1);
    req_wdata0 = d0;
    req_wdata1 = d1;
  endtask

  initial begin
    drive(2'b00, 2'b00, 2'b00, 8'h0, 8'h0, '0, '0);
    #1;
    do_reset();

    // Tie-break after reset: 0, 1, 0, 1.
    pat = '0;
    drive(2'b11, 2'b00, 2'b00, 8'h03, 8'h04, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      pat = {pat[9:0], last_ready};
    end
    check("alt_grants", 32'(pat[7:0]), 32'(8'b01_10_01_10));

    // Read path through requester 1.
    we_cnt = 0;
    drive(2'b10, 2'b10, 2'b00, 8'h00, 8'h10, '0, 19'h12345);
    step();
    drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h10, '0, '0);
    step();
    check("rd_rsp_valid", 32'(rsp_valid), 32'(2'b10));
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'(19'h12345));
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, '0, '0);
    step();
    check("rd_hold", 32'(rsp_rdata), 32'(19'h12345));
    check("we_pulses", 32'(we_cnt), 32'(1));

    // Locked burst with requester 0 stalled behind it.
    drive(2'b01, 2'b00, 2'b00, 8'h20, 8'h00, '0, '0);
    step();
    pat = '0;
    drive(2'b11, 2'b00, 2'b10, 8'h21, 8'h30, '0, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      pat = {pat[9:0], last_ready};
    end
    check("burst_grants", 32'(pat), 32'(12'b10_10_10_10_01_10));

    // Early release after two beats.
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, '0, '0);
    step();
    drive(2'b10, 2'b00, 2'b10, 8'h00, 8'h31, '0, '0);
    step();
    drive(2'b11, 2'b00, 2'b00, 8'h22, 8'h32, '0, '0);
    step();
    check("early_owner", 32'(last_ready), 32'(2'b10));
    step();
    check("early_rel", 32'(last_ready), 32'(2'b01));

    // Owner goes idle inside the lock.
    drive(2'b10, 2'b00, 2'b10, 8'h00, 8'h33, '0, '0);
    step();
    drive(2'b01, 2'b00, 2'b00, 8'h23, 8'h00, '0, '0);
    step();
    check("idle_gap", 32'(last_ready), 32'(2'b00));
    step();
    check("after_idle", 32'(last_ready), 32'(2'b01));

    // Reset hits during a lock right after a read was accepted.
    drive(2'b10, 2'b00, 2'b10, 8'h00, 8'h34, '0, '0);
    step();
    step();
    check("mid_rsp_pending", 32'(rsp_valid), 32'(2'b10));
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 8'h05, 8'h06, '0, '0);
    step();
    check("post_rst_tie", 32'(last_ready), 32'(2'b01));

    // Random traffic honouring the hold-while-waiting rule.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && !last_ready[r]) begin
          if ($urandom_range(9) == 0) req_valid[r] = 1'b0;
        end else begin
          req_valid[r] = ($urandom_range(3) != 0);
          req_we[r]    = 1'($urandom_range(1));
          req_lock[r]  = ($urandom_range(2) != 0);
          if (r == 0) begin
            req_addr0  = AW'($urandom_range(63));
            req_wdata0 = DW'($urandom);
          end else begin
            req_addr1  = AW'($urandom_range(63));
            req_wdata1 = DW'($urandom);
          end
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
